multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the 16-bit simplified MIPS datapath. It replaces the single-cycle decoder with a Moore state machine that steps each instruction through fetch, decode, execute and writeback on a shared ALU. Each state drives the datapath enables and mux selects. The block sits between the IR opcode field, the ALU Zero flag and the datapath control inputs.

## Interface
- No parameters.
- clock  in  1  system clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high; forces FETCH and clears internal registers
- Op  in  4  IR[15:12] from the instruction register
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register load enable
- IRWrite  out  1  instruction register load enable
- RegWrite  out  1  register file write enable
- RegDst  out  1  1: write IR[7:6]; 0: write IR[9:8]
- ALUSrcA  out  1  0: PC; 1: RD1
- ALUSrcB  out  2  00: RD2; 01: constant 2; 10: sign-extended imm; 11: sign-extended imm << 1
- ALUControl  out  4  ALU op, encoded the same way as the existing ALU
- PCSource  out  1  0: ALU result; 1: ALUOut register (branch target)
- Halted  out  1  high in HALT
- State  out  3  current state code, for debug

## Operation
- States and codes: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, BRANCH=4, WB=5, HALT=6. Code 7 is illegal and goes to FETCH.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=0010, PCSource=0. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=0010 (branch target into ALUOut). Op is latched into op_q.
  - Next state for Op 0000–0110: EXEC_R.
  - Op 0111: EXEC_I.
  - Op 1010 or 1011: BRANCH.
  - Op 1111: HALT.
  - Any other Op: FETCH (NOP).
- EXEC_R: ALUSrcA=1, ALUSrcB=00. ALUControl is decoded from op_q:
  - add=0010, sub=0110, and=0000, or=0001
  - nor=1100, nand=1101, slt=0111
  - Next state is WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUControl=0010. Next state is WB.
- WB: RegWrite=1. RegDst=1 if op_q is 0000–0110, else 0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=0110, PCSource=1. Next state is FETCH.
  - PCWrite=1 only for beq (1010) with Zero=1, or bne (1011) with Zero=0.
- HALT: Halted=1, all enables 0. Stays in HALT until reset.
- Any output not listed for a state is 0.

## Timing
- Reset: State=FETCH, op_q=0, Halted=0, and the FETCH output values hold while reset is high. The first fetch completes on the first falling edge after reset deasserts.
- Latency in cycles:
  - R-type and addi: 4.
  - Branch: 3, whether taken or not.
  - NOP: 2.
  - Halt: 2 to reach HALT.
- All outputs depend only on State and op_q, except BRANCH PCWrite, which also depends on Zero.
- Op is sampled only at the DECODE exit edge. Changes to Op in later states are ignored.
- Reset asserted mid-instruction aborts it immediately. A write in progress in WB is dropped if reset rises before the falling edge.

## Configuration
- MULTICYCLE_RETIRE_COUNT_EN
  - Defined: adds output Retired [15:0]. It is reset to 0 and increments on every exit from WB or BRANCH. It wraps from 0xFFFF to 0, and NOP does not count.
  - Undefined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- addi sequence: reset, then Op=0111 → State 0,1,3,5,0. RegWrite=1 only in state 5, with RegDst=0. ALUSrcB=10 in state 3.
- R-type decode: Op=0100 (nor) → ALUControl=1100 in EXEC_R; RegDst=1 and RegWrite=1 in WB. Repeat for each of the seven ops and check the encoding table.
- Branch conditions, each in BRANCH:
  - bne, Zero=1 → PCWrite=0.
  - bne, Zero=0 → PCWrite=1, PCSource=1.
  - beq, Zero=1 → PCWrite=1.
  - beq, Zero=0 → PCWrite=0.
- Halt: Op=1111 → DECODE then HALT with Halted=1. It stays there for 20 cycles with PCWrite=0. Reset then returns State=0 and Halted=0.
- Reset mid-instruction: assert reset in EXEC_R, asynchronously between edges → State=0 before the next edge and RegWrite never pulses.
- Op changes after DECODE: feed sub, then change Op to 0111 during EXEC_R → ALUControl stays 0110 and RegDst=1 in WB.
- With MULTICYCLE_RETIRE_COUNT_EN defined: run 3 addi, 1 branch and 1 NOP → Retired=4.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer stepping the 16-bit MIPS datapath through
// fetch / decode / execute / writeback on a shared ALU. State advances on the
// falling clock edge. Optional build macro: MULTICYCLE_RETIRE_COUNT_EN adds a
// 16-bit retired-instruction counter output.
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Op,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       PCSource,
    output logic       Halted,
`ifdef MULTICYCLE_RETIRE_COUNT_EN
    output logic [15:0] Retired,
`endif
    output logic [2:0] State
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned ALUC_W  = 4;

    localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALU_NAND = 4'b1101;

    localparam logic [OP_W-1:0] OP_ADDI = 4'b0111;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b1010;
    localparam logic [OP_W-1:0] OP_BNE  = 4'b1011;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;
    localparam logic [OP_W-1:0] OP_RMAX = 4'b0110;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC_R  = 3'd2,
        S_EXEC_I  = 3'd3,
        S_BRANCH  = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;

    // State register, falling-edge clocked
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode capture on the DECODE exit edge; later Op changes are ignored
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            op_q <= '0;
        end else if (state_q == S_DECODE) begin
            op_q <= Op;
        end
    end

`ifdef MULTICYCLE_RETIRE_COUNT_EN
    // Retired-instruction counter: one per exit from WB or BRANCH, wraps naturally
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            Retired <= '0;
        end else if (state_q == S_WB || state_q == S_BRANCH) begin
            Retired <= Retired + 16'd1;
        end
    end
`endif

    // Next-state and per-state datapath controls
    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_AND;
        PCSource   = 1'b0;
        Halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite    = 1'b1;
                PCWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                if (Op <= OP_RMAX) begin
                    state_d = S_EXEC_R;
                end else if (Op == OP_ADDI) begin
                    state_d = S_EXEC_I;
                end else if (Op == OP_BEQ || Op == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (Op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                case (op_q)
                    4'd0:    ALUControl = ALU_ADD;
                    4'd1:    ALUControl = ALU_SUB;
                    4'd2:    ALUControl = ALU_AND;
                    4'd3:    ALUControl = ALU_OR;
                    4'd4:    ALUControl = ALU_NOR;
                    4'd5:    ALUControl = ALU_NAND;
                    4'd6:    ALUControl = ALU_SLT;
                    default: ALUControl = ALU_AND;
                endcase
                state_d = S_WB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = S_WB;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (op_q <= OP_RMAX);
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                PCSource   = 1'b1;
                PCWrite    = (op_q == OP_BEQ && Zero) || (op_q == OP_BNE && !Zero);
                state_d    = S_FETCH;
            end
            S_HALT: begin
                Halted  = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign State = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed plus randomized instruction streams checked
// against a per-instruction phase model built from the state/output tables.
module tb_multicycle_control;

    logic        clock;
    logic        reset;
    logic [3:0]  Op;
    logic        Zero;
    logic        PCWrite, IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, Halted;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  State;
`ifdef MULTICYCLE_RETIRE_COUNT_EN
    logic [15:0] Retired;
`endif

    int checks   = 0;
    int failures = 0;
    int retired_exp = 0;

    multicycle_control dut (
        .clock      (clock),
        .reset      (reset),
        .Op         (Op),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSource   (PCSource),
        .Halted     (Halted),
`ifdef MULTICYCLE_RETIRE_COUNT_EN
        .Retired    (Retired),
`endif
        .State      (State)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected output vector {State,PCWrite,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUControl,PCSource,Halted}
    function automatic logic [16:0] exp_out(input int st, input logic [3:0] op, input logic z);
        logic       pcw, irw, rw, rd, asa, pcs, hlt;
        logic [1:0] asb;
        logic [3:0] aluc;
        pcw = 0; irw = 0; rw = 0; rd = 0; asa = 0; pcs = 0; hlt = 0; asb = 2'b00; aluc = 4'b0000;
        case (st)
            0: begin irw = 1; pcw = 1; asb = 2'b01; aluc = 4'b0010; end
            1: begin asb = 2'b11; aluc = 4'b0010; end
            2: begin
                asa = 1;
                case (op)
                    4'd0: aluc = 4'b0010;
                    4'd1: aluc = 4'b0110;
                    4'd2: aluc = 4'b0000;
                    4'd3: aluc = 4'b0001;
                    4'd4: aluc = 4'b1100;
                    4'd5: aluc = 4'b1101;
                    default: aluc = 4'b0111;
                endcase
            end
            3: begin asa = 1; asb = 2'b10; aluc = 4'b0010; end
            4: begin
                asa = 1; aluc = 4'b0110; pcs = 1;
                pcw = (op == 4'd10 && z) || (op == 4'd11 && !z);
            end
            5: begin rw = 1; rd = (op <= 4'd6); end
            6: begin hlt = 1; end
            default: ;
        endcase
        return {3'(st), pcw, irw, rw, rd, asa, asb, aluc, pcs, hlt};
    endfunction

    task automatic check_out(input string tag, input logic [16:0] exp);
        logic [16:0] act;
        act = {State, PCWrite, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUControl, PCSource, Halted};
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

`ifdef MULTICYCLE_RETIRE_COUNT_EN
    task automatic check_retired(input string tag);
        checks++;
        assert (Retired === 16'(retired_exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, Retired, retired_exp);
        end
    endtask
`endif

    // One instruction from FETCH. noise<0: random Op outside DECODE; zval<0: random Zero;
    // abort_idx>=0: assert reset asynchronously mid-cycle at that phase.
    // Entered and left just after a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [3:0] op, input int noise, input int zval, input int abort_idx);
        int  seq[$];
        bool_retire: begin end
        seq = {0, 1};
        if (op <= 4'd6)                    seq.push_back(2);
        else if (op == 4'd7)               seq.push_back(3);
        else if (op == 4'd10 || op == 4'd11) seq.push_back(4);
        else if (op == 4'd15)              seq.push_back(6);
        if (op <= 4'd7) seq.push_back(5);
        for (int i = 0; i < seq.size(); i++) begin
            @(posedge clock);
            Op   = (seq[i] == 1) ? op : ((noise < 0) ? 4'($urandom) : 4'(noise));
            Zero = (zval < 0) ? 1'($urandom) : 1'(zval);
            #1;
            check_out($sformatf("op%0d_st%0d", op, seq[i]), exp_out(seq[i], op, Zero));
            if (i == abort_idx) begin
                #2 reset = 1'b1;
                #1 check_out("async_reset_now", exp_out(0, op, Zero));
                @(negedge clock);
                #1 check_out("reset_held_edge", exp_out(0, op, Zero));
                retired_exp = 0;
                reset = 1'b0;
                return;
            end
            @(negedge clock);
        end
        if (op <= 4'd7 || op == 4'd10 || op == 4'd11) retired_exp++;
    endtask

    initial begin
        reset = 1'b1;
        Op    = 4'd0;
        Zero  = 1'b0;
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1 check_out("reset_fetch", exp_out(0, 4'd0, 1'b0));
        @(negedge clock);
        #1 reset = 1'b0;

        // addi sequence
        run_instr(4'd7, -1, -1, -1);
        // every R-type op, with Op wiggling after DECODE
        for (int k = 0; k <= 6; k++) run_instr(4'(k), -1, -1, -1);
        // sub with Op forced to addi in later states
        run_instr(4'd1, 7, -1, -1);
        // branch conditions
        run_instr(4'd11, -1, 1, -1);
        run_instr(4'd11, -1, 0, -1);
        run_instr(4'd10, -1, 1, -1);
        run_instr(4'd10, -1, 0, -1);
        // NOP
        run_instr(4'd12, -1, -1, -1);
        // reset in EXEC_R
        run_instr(4'd4, -1, -1, 2);
        run_instr(4'd7, -1, -1, -1);

        // randomized stream, halt excluded
        for (int k = 0; k < 60; k++) begin
            logic [3:0] rop;
            rop = 4'($urandom);
            if (rop == 4'd15) rop = 4'd7;
            run_instr(rop, -1, -1, -1);
        end
`ifdef MULTICYCLE_RETIRE_COUNT_EN
        check_retired("retired_stream");
`endif

        // halt, hold for 20 cycles, then reset
        run_instr(4'd15, -1, -1, -1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            Op = 4'($urandom); Zero = 1'($urandom);
            #1 check_out("halt_hold", exp_out(6, Op, Zero));
            @(negedge clock);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check_out("halt_reset", exp_out(0, 4'd0, 1'b0));
        retired_exp = 0;
        @(negedge clock);
        #1 reset = 1'b0;

        // 3 addi, 1 branch, 1 NOP
        for (int k = 0; k < 3; k++) run_instr(4'd7, -1, -1, -1);
        run_instr(4'd10, -1, -1, -1);
        run_instr(4'd13, -1, -1, -1);
`ifdef MULTICYCLE_RETIRE_COUNT_EN
        check_retired("retired_four");
`endif
        run_instr(4'd3, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
